// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode display with
// frame-synchronous data update and PWM-style brightness control.
//
// Each digit slot lasts 16 brightness phases. Each phase lasts P_STEP clocks.
// The digit is lit during phases 0..bright_q. New digit data is accepted into
// a single pending buffer through a valid/ready handshake. The data is copied
// to the displayed shadow register only at a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Ports
//   i_Clk      : clock. All state changes on its rising edge.
//   i_Reset    : synchronous active-high reset.
//   i_Enable   : 1 = scan the display. 0 = all digits dark and counters at 0.
//   i_Data     : four 4-bit digit codes. Digit n is i_Data[4n+3:4n].
//   i_Valid    : i_Data is offered this cycle.
//   o_Ready    : registered. High when the pending buffer is empty.
//   i_Blank    : per-digit blanking, applied combinationally to the current slot.
//   i_Bright   : brightness. The digit is lit for (i_Bright+1) of 16 phases.
//                Sampled at the frame boundary and on scan entry.
//   o_Sel      : index of the current digit slot.
//   o_Anodos   : active-low anode enables. 4'b1111 = dark.
//   o_Nibble   : digit code of the current slot, taken from the shadow register.
//   o_Frame    : one-cycle pulse on the first cycle that shows a new frame.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int P_STEP = 1562
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [15:0] i_Data,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic [3:0]  i_Blank,
    input  logic [3:0]  i_Bright,
    output logic [1:0]  o_Sel,
    output logic [3:0]  o_Anodos,
    output logic [3:0]  o_Nibble,
    output logic        o_Frame
);

    localparam int STEP_W = (P_STEP > 1) ? $clog2(P_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(P_STEP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_reg;
    logic [STEP_W-1:0] step_reg;
    logic [3:0]        phase_reg;
    logic [1:0]        slot_reg;
    logic [15:0]       shadow_reg;
    logic [15:0]       pending_reg;
    logic              pending_full_reg;
    logic              ready_reg;
    logic              frame_reg;
    logic [3:0]        bright_reg;

    logic              step_wrap;
    logic              boundary;
    logic              accept;
    logic              pending_full_next;
    logic              lit;

    assign step_wrap = (step_reg == STEP_LAST);

    // The last step of the last phase of slot 3. Qualified by i_Enable because
    // the scan is abandoned on the same edge when i_Enable is low.
    assign boundary  = (state_reg == SCAN) && i_Enable && step_wrap &&
                       (phase_reg == 4'hF) && (slot_reg == 2'd3);

    assign accept    = i_Valid && ready_reg;

    // An accept is only possible while the buffer is empty. So "set on accept"
    // and "clear on boundary" never compete for a full buffer.
    always_comb begin
        pending_full_next = pending_full_reg;
        if (accept) begin
            pending_full_next = 1'b1;
        end else if (boundary) begin
            pending_full_next = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg        <= IDLE;
            step_reg         <= '0;
            phase_reg        <= 4'h0;
            slot_reg         <= 2'd0;
            shadow_reg       <= 16'h0000;
            pending_reg      <= 16'h0000;
            pending_full_reg <= 1'b0;
            ready_reg        <= 1'b1;
            frame_reg        <= 1'b0;
            bright_reg       <= 4'hF;
        end else begin
            pending_full_reg <= pending_full_next;
            ready_reg        <= ~pending_full_next;
            frame_reg        <= boundary;

            if (accept) begin
                pending_reg <= i_Data;
            end
            if (boundary && pending_full_reg) begin
                shadow_reg <= pending_reg;
            end

            case (state_reg)
                IDLE: begin
                    step_reg  <= '0;
                    phase_reg <= 4'h0;
                    slot_reg  <= 2'd0;
                    if (i_Enable) begin
                        state_reg  <= SCAN;
                        bright_reg <= i_Bright;
                    end
                end
                SCAN: begin
                    if (!i_Enable) begin
                        state_reg <= IDLE;
                        step_reg  <= '0;
                        phase_reg <= 4'h0;
                        slot_reg  <= 2'd0;
                    end else begin
                        step_reg <= step_wrap ? '0 : step_reg + STEP_W'(1);
                        if (step_wrap) begin
                            phase_reg <= phase_reg + 4'd1;
                            if (phase_reg == 4'hF) begin
                                slot_reg <= slot_reg + 2'd1;
                            end
                        end
                        if (boundary) begin
                            bright_reg <= i_Bright;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // i_Blank is combinational on purpose. It can hide a digit at once, without
    // waiting for the next frame.
    assign lit = (state_reg == SCAN) && (phase_reg <= bright_reg) && !i_Blank[slot_reg];

    // Slot 0 drives the MSB anode: slot n pulls bit (3-n) low.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign o_Anodos[3-gi] = ~(lit && (slot_reg == 2'(gi)));
        end
    endgenerate

    assign o_Sel    = slot_reg;
    assign o_Nibble = shadow_reg[{slot_reg, 2'b00} +: 4];
    assign o_Ready  = ready_reg;
    assign o_Frame  = frame_reg;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter P_STEP, default 1562, clock cycles per brightness phase step; one digit slot SHALL be 16*P_STEP cycles.
REQ-002 i_Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_Reset  input  1  reset, synchronous and active-high, sampled on the rising edge of i_Clk.
REQ-004 i_Enable  input  1  1 = scan display; 0 = all digits dark and counters held at zero.
REQ-005 i_Data  input  16  four 4-bit digit codes; digit n is i_Data[4n+3:4n].
REQ-006 i_Valid  input  1  i_Data is offered this cycle.
REQ-007 o_Ready  output  1  block can accept i_Data this cycle.
REQ-008 i_Blank  input  4  i_Blank[n]=1 forces digit n dark.
REQ-009 i_Bright  input  4  brightness; digit lit for (i_Bright+1) of 16 phases.
REQ-010 o_Sel  output  2  index of the current digit slot.
REQ-011 o_Anodos  output  4  active-low anodes: slot 0 = 4'b0111, 1 = 4'b1011, 2 = 4'b1101, 3 = 4'b1110; 4'b1111 = dark.
REQ-012 o_Nibble  output  4  digit code for the current slot, taken from the shadow register.
REQ-013 o_Frame  output  1  one-cycle pulse at the frame boundary.

Function
REQ-014 FSM states SHALL be IDLE and SCAN; IDLE->SCAN when i_Enable=1; SCAN->IDLE on the first cycle i_Enable=0.
REQ-015 In IDLE: step counter, 4-bit phase counter and slot index SHALL be held at 0; o_Anodos SHALL be 4'b1111 and o_Frame 0.
REQ-016 In SCAN, step counter SHALL count 0..P_STEP-1 and wrap to 0; on wrap, phase SHALL increment modulo 16.
REQ-017 On step wrap with phase=15, slot SHALL increment modulo 4 (3->0).
REQ-018 The frame boundary SHALL be the cycle on which the step counter wraps, phase=15 and slot=3.
REQ-019 The handshake is a 1-entry pending buffer; o_Ready SHALL equal NOT pending_full and SHALL be registered.
REQ-020 When i_Valid=1 and o_Ready=1, i_Data SHALL be captured into pending and pending_full set on the next edge; i_Valid while o_Ready=0 SHALL be ignored, with no loss of pending data.
REQ-021 At the frame boundary with pending_full=1, shadow SHALL load pending and pending_full SHALL clear.
REQ-022 An accept on the frame-boundary cycle SHALL go to pending, not shadow, and becomes visible at the next boundary.
REQ-023 i_Bright SHALL be sampled into bright_q only at the frame boundary, and on IDLE->SCAN entry; mid-frame changes SHALL have no effect.
REQ-024 Digit o_Sel SHALL be lit (o_Anodos per REQ-011) only when state=SCAN, phase <= bright_q and i_Blank[o_Sel]=0; otherwise o_Anodos=4'b1111.
REQ-025 i_Blank SHALL act combinationally on the current slot and is not frame-synchronised.
REQ-026 o_Sel and o_Nibble SHALL track the slot index in both states (0 in IDLE); o_Nibble = shadow[4*o_Sel+3 : 4*o_Sel].
REQ-027 o_Frame SHALL be 1 for exactly the cycle after each frame boundary edge, i.e. when the new shadow first drives outputs.
REQ-028 Leaving SCAN mid-frame SHALL retain shadow, pending and bright_q, except that bright_q is re-sampled on re-entry (REQ-023); re-entry SHALL restart at slot 0, phase 0, step 0.
REQ-029 No combinational path SHALL exist from i_Data, i_Valid or i_Bright to any output.

Reset
REQ-030 Reset SHALL take priority over all other inputs, including an active handshake.
REQ-031 Reset values: state=IDLE, counters=0, shadow=16'h0000, pending_full=0, bright_q=4'hF.
REQ-032 Reset output values: o_Ready=1, o_Anodos=4'b1111, o_Sel=0, o_Nibble=0, o_Frame=0.
REQ-033 Reset asserted mid-frame SHALL clear state by the following edge, with no partial frame or shadow update.

Verification (P_STEP=2: slot=32 cycles, frame=128 cycles)
REQ-034 Reset, then i_Enable=1, i_Bright=F, i_Blank=0 -> o_Anodos cycles 0111/1011/1101/1110, 32 cycles each; o_Frame pulses every 128 cycles.
REQ-035 Write 16'h4321 mid-frame -> o_Ready=0 until the boundary; from o_Frame onward o_Nibble reads 1,2,3,4 for slots 0..3; o_Ready returns to 1.
REQ-036 Two back-to-back writes 16'hAAAA then 16'h5555 within one frame -> second held off (o_Ready=0); display shows AAAA next frame and 5555 the frame after.
REQ-037 i_Bright=3 -> each slot lit for 8 cycles (phases 0..3) then dark for 24; i_Bright changed to 0 mid-frame -> no change until the boundary, then 2 lit cycles per slot.
REQ-038 i_Blank=4'b0100 -> slot 2 stays 4'b1111 while o_Sel=2 and o_Nibble still valid; other slots unaffected.
REQ-039 i_Enable dropped during slot 2 -> next cycle o_Anodos=1111, o_Sel=0; re-enable -> restart at slot 0 with shadow intact. Reset pulse during a pending write -> o_Ready=1, shadow=0.
